// File: rtl/packet_switch_dbg_pkg.sv
// Shared types and constants for the TX debug counter poller.
package packet_switch_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } poll_state_t;

    // Counter slots in the TX debug CSR block, in scan order.
    localparam int DMA2IWADJ_CH0  = 0;
    localparam int DMA2IWADJ_CH1  = 1;
    localparam int DMA2IWADJ_CH2  = 2;
    localparam int IWADJ2IARB_CH0 = 3;
    localparam int IWADJ2IARB_CH1 = 4;
    localparam int IWADJ2IARB_CH2 = 5;
    localparam int USER2IARB      = 6;
    localparam int IARB2HSSI      = 7;

endpackage

// File: rtl/packet_switch_dbg_delta_track.sv
// Per-counter snapshot holder: last value, wrap-safe delta and stall detection.
module packet_switch_dbg_delta_track #(
    parameter int CNTR_WIDTH  = 32,
    parameter int STALL_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd,
    input  logic [CNTR_WIDTH-1:0] sample,
    output logic [CNTR_WIDTH-1:0] snap_cnt,
    output logic [CNTR_WIDTH-1:0] snap_delta,
    output logic                  stall_flag
);

    localparam int STALL_W = $clog2(STALL_SCANS + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_SCANS);

    logic [CNTR_WIDTH-1:0] delta_next;
    logic [STALL_W-1:0]    stall_cnt;
    logic [STALL_W-1:0]    stall_cnt_next;

    // Modular difference against the held snapshot and saturating zero-delta run length.
    always_comb begin
        delta_next     = sample - snap_cnt;
        stall_cnt_next = stall_cnt;
        if (delta_next != '0) begin
            stall_cnt_next = '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt_next = stall_cnt + 1'b1;
        end
    end

    // Snapshot state only moves on the scan-complete strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_cnt   <= '0;
            snap_delta <= '0;
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
        end else if (upd) begin
            snap_cnt   <= sample;
            snap_delta <= delta_next;
            stall_cnt  <= stall_cnt_next;
            stall_flag <= (stall_cnt_next >= STALL_MAX);
        end
    end

endmodule

// File: rtl/packet_switch_tx_dbg_cntr_poller.sv
// AVMM read initiator that periodically scans the TX debug counters and
// publishes a coherent snapshot, per-counter deltas and stall flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no scan; waiting for period tick or start pulse
// ST_ISSUE  | one-cycle read strobe for counter idx
// ST_WAIT   | waiting for readdatavalid (bounded by the wait timer)
// ST_UPDATE | all shadows captured; commit snapshot next edge
module packet_switch_tx_dbg_cntr_poller
    import packet_switch_dbg_pkg::*;
#(
    parameter int          NUM_CNTR       = IARB2HSSI + 1,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned ADDR_STRIDE    = 1,
    parameter int          ADDR_WIDTH     = 8,
    parameter int          DATA_WIDTH     = 32,
    parameter int          CNTR_WIDTH     = 32,
    parameter int          PERIOD_CYCLES  = 1024,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          STALL_SCANS    = 4,
    localparam int         IDX_W          = $clog2(NUM_CNTR)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                start,
    input  logic                                err_clr,
    output logic [ADDR_WIDTH-1:0]               avmm_address,
    output logic                                avmm_read,
    output logic                                avmm_write,
    output logic [DATA_WIDTH-1:0]               avmm_writedata,
    output logic [DATA_WIDTH/8-1:0]             avmm_byteenable,
    input  logic [DATA_WIDTH-1:0]               avmm_readdata,
    input  logic                                avmm_readdatavalid,
    output logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] snap_cnt,
    output logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] snap_delta,
    output logic                                snap_valid,
    output logic [NUM_CNTR-1:0]                 stall_flag,
    output logic                                busy,
    output logic                                err_timeout,
    output logic [IDX_W-1:0]                    err_idx,
    output logic                                err_overrun
);

    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CNTR - 1);

    poll_state_t state;
    poll_state_t state_next;

    logic [PER_W-1:0]                    period_cnt;
    logic                                tick;
    logic [TMO_W-1:0]                    wait_cnt;
    logic                                timeout;
    logic                                rd_done;
    logic [IDX_W-1:0]                    idx;
    logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0] shadow;
    logic                                upd;

    assign avmm_write      = 1'b0;
    assign avmm_writedata  = '0;
    assign avmm_byteenable = '1;

    assign tick    = enable && (period_cnt == PER_LAST);
    assign rd_done = (state == ST_WAIT) && avmm_readdatavalid;
    // Data arriving on the expiry cycle is still accepted.
    assign timeout = (state == ST_WAIT) && !avmm_readdatavalid && (wait_cnt == TMO_LAST);
    assign upd     = (state == ST_UPDATE);

    // Free-running scan period timer, parked at zero while auto-scan is off.
    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start or tick is only accepted from idle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (tick || start) state_next = ST_ISSUE;
            ST_ISSUE:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (avmm_readdatavalid) begin
                    state_next = (idx == IDX_LAST) ? ST_UPDATE : ST_ISSUE;
                end else if (timeout) begin
                    state_next = ST_IDLE;
                end
            end
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bus-facing outputs; address is only driven alongside the read strobe.
    always_comb begin
        avmm_read    = 1'b0;
        avmm_address = '0;
        busy         = (state != ST_IDLE);
        if (state == ST_ISSUE) begin
            avmm_read    = 1'b1;
            avmm_address = ADDR_WIDTH'(BASE_ADDR + ADDR_STRIDE * 32'(idx));
        end
    end

    // Wait timer runs only while a read is outstanding.
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Counter index: restarts at zero every scan, advances on each accepted read.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            idx <= '0;
        end else if (rd_done && idx != IDX_LAST) begin
            idx <= idx + 1'b1;
        end
    end

    // Shadow capture keeps a partially completed scan out of the published snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (rd_done) begin
            shadow[idx] <= avmm_readdata[CNTR_WIDTH-1:0];
        end
    end

    // Snapshot-valid pulse lines up with the tracker outputs it announces.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= upd;
        end
    end

    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_idx     <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (timeout) begin
                err_timeout <= 1'b1;
                err_idx     <= idx;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
            if (tick && busy) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_track
        packet_switch_dbg_delta_track #(
            .CNTR_WIDTH  (CNTR_WIDTH),
            .STALL_SCANS (STALL_SCANS)
        ) u_track (
            .clk        (clk),
            .rst        (rst),
            .upd        (upd),
            .sample     (shadow[g]),
            .snap_cnt   (snap_cnt[g]),
            .snap_delta (snap_delta[g]),
            .stall_flag (stall_flag[g])
        );
    end

endmodule

// File: tb/tb_packet_switch_tx_dbg_cntr_poller.sv
// Bench for the TX debug counter poller: AVMM responder model plus scoreboards
// for read addresses and published snapshots.
module tb_packet_switch_tx_dbg_cntr_poller;
    import packet_switch_dbg_pkg::*;

    localparam int N  = 8;
    localparam int CW = 32;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TMO = 64;
    localparam int STALL = 4;

    logic clk = 1'b0;
    logic rst, enable, start, err_clr;
    logic [AW-1:0] avmm_address;
    logic avmm_read, avmm_write;
    logic [DW-1:0] avmm_writedata, avmm_readdata;
    logic [DW/8-1:0] avmm_byteenable;
    logic avmm_readdatavalid;
    logic [N-1:0][CW-1:0] snap_cnt, snap_delta;
    logic snap_valid, busy, err_timeout, err_overrun;
    logic [N-1:0] stall_flag;
    logic [2:0] err_idx;

    always #5 clk = ~clk;

    packet_switch_tx_dbg_cntr_poller dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .err_clr(err_clr),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
        .snap_cnt(snap_cnt), .snap_delta(snap_delta), .snap_valid(snap_valid),
        .stall_flag(stall_flag), .busy(busy), .err_timeout(err_timeout),
        .err_idx(err_idx), .err_overrun(err_overrun)
    );

    typedef struct {
        logic [N-1:0][CW-1:0] cnt;
        logic [N-1:0][CW-1:0] delta;
        logic [N-1:0]         stall;
    } exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sv_count = 0;
    int busy_cyc = 0;
    int rd_cyc_last = 0;
    int lat = 2;
    int drop_idx = -1;
    bit inject_rdv = 1'b0;

    exp_t exp_q[$];
    int   exp_addr_q[$];
    rsp_t rsp_q[$];

    logic [CW-1:0] cntr_val [N];
    logic [CW-1:0] m_snap [N];
    int            m_stall [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (busy === 1'b1) busy_cyc++;

    // Snapshot scoreboard: every snap_valid pops one expected scan result.
    always @(negedge clk) begin : snap_mon
        exp_t e;
        if (snap_valid === 1'b1) begin
            sv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_snap_valid at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                checks += 2;
                if (snap_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL snap_cnt got %h expected %h", snap_cnt, e.cnt);
                end
                if (snap_delta !== e.delta) begin
                    errors++;
                    $display("FAIL snap_delta got %h expected %h", snap_delta, e.delta);
                end
                if (stall_flag !== e.stall) begin
                    errors++;
                    $display("FAIL stall_flag got %b expected %b", stall_flag, e.stall);
                end
            end
        end
    end

    // AVMM slave model: checks each read address and answers after lat cycles.
    initial begin : responder
        rsp_t r;
        int   ea;
        avmm_readdata      = '0;
        avmm_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            avmm_readdatavalid = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = r.data;
            end
            if (inject_rdv) begin
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = 32'hDEAD_BEEF;
                inject_rdv         = 1'b0;
            end
            if (avmm_read === 1'b1) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read addr %0d at cycle %0d", avmm_address, cyc);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (int'(avmm_address) != ea) begin
                        errors++;
                        $display("FAIL read_addr got %0d expected %0d", avmm_address, ea);
                    end
                end
                checks++;
                if (rsp_q.size() != 0) begin
                    errors++;
                    $display("FAIL outstanding_reads got %0d expected 0", rsp_q.size());
                end
                rd_cyc_last = cyc;
                if (int'(avmm_address) < N && int'(avmm_address) != drop_idx) begin
                    r.due  = cyc + lat;
                    r.data = cntr_val[avmm_address[2:0]];
                    rsp_q.push_back(r);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_snap[i]  = '0;
            m_stall[i] = 0;
        end
    endtask

    task automatic push_addrs(input int nreads);
        for (int i = 0; i < nreads; i++) exp_addr_q.push_back(i);
    endtask

    // Expected result of a complete scan over the current counter values.
    task automatic push_expect();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.cnt[i]   = cntr_val[i];
            e.delta[i] = cntr_val[i] - m_snap[i];
            if (e.delta[i] == '0) begin
                if (m_stall[i] < STALL) m_stall[i]++;
            end else begin
                m_stall[i] = 0;
            end
            e.stall[i] = (m_stall[i] >= STALL);
            m_snap[i]  = cntr_val[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_snap(input int budget, input string name);
        int k = 0;
        while (snap_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s snap_valid got 0 expected 1 within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    task automatic run_scan(input string name);
        push_addrs(N);
        push_expect();
        pulse_start();
        wait_snap(200, name);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; start = 1'b0; err_clr = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) cntr_val[i] = CW'(32'h10 * i);
        repeat (3) @(negedge clk);
        checks++;
        if ({avmm_read, avmm_write, snap_valid, busy, err_timeout, err_overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000",
                     {avmm_read, avmm_write, snap_valid, busy, err_timeout, err_overrun});
        end
        checks++;
        if (avmm_byteenable !== 4'hF || avmm_writedata !== '0 || avmm_address !== '0) begin
            errors++;
            $display("FAIL reset_bus got be=%h wd=%h addr=%h expected F 0 0",
                     avmm_byteenable, avmm_writedata, avmm_address);
        end
        checks++;
        if (snap_cnt !== '0 || snap_delta !== '0 || stall_flag !== '0 || err_idx !== '0) begin
            errors++;
            $display("FAIL reset_snap got cnt=%h delta=%h stall=%b eidx=%0d expected zeros",
                     snap_cnt, snap_delta, stall_flag, err_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Auto-scan from the period timer, counters 0x10*i, latency 2.
    task automatic test_periodic_scan();
        int sv0;
        lat = 2;
        sv0 = sv_count;
        busy_cyc = 0;
        push_addrs(N);
        push_expect();
        enable = 1'b1;
        wait_snap(1100, "periodic_scan");
        enable = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (sv_count - sv0 != 1) begin
            errors++;
            $display("FAIL periodic_snap_count got %0d expected 1", sv_count - sv0);
        end
        checks++;
        if (busy_cyc != N * (1 + 2) + 1) begin
            errors++;
            $display("FAIL scan_length got %0d expected %0d", busy_cyc, N * 3 + 1);
        end
        checks++;
        if (err_overrun !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL periodic_errs got %b%b expected 00", err_overrun, err_timeout);
        end
    endtask

    task automatic test_wrap();
        cntr_val[IWADJ2IARB_CH0] = 32'hFFFF_FFF0;
        run_scan("wrap_pre");
        cntr_val[IWADJ2IARB_CH0] = 32'h0000_0010;
        run_scan("wrap_post");
        checks++;
        if (snap_delta[IWADJ2IARB_CH0] !== 32'h20 || stall_flag[IWADJ2IARB_CH0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_delta got %h stall %b expected 00000020 stall 0",
                     snap_delta[IWADJ2IARB_CH0], stall_flag[IWADJ2IARB_CH0]);
        end
    endtask

    task automatic test_stall();
        cntr_val[IARB2HSSI] = 32'h55;
        for (int k = 1; k <= 5; k++) begin
            run_scan("stall_scan");
            checks++;
            if (stall_flag[IARB2HSSI] !== (k == 5)) begin
                errors++;
                $display("FAIL stall7_scan%0d got %b expected %b", k, stall_flag[IARB2HSSI], k == 5);
            end
        end
        cntr_val[IARB2HSSI] = 32'h56;
        run_scan("stall_release");
        checks++;
        if (stall_flag[IARB2HSSI] !== 1'b0 || snap_delta[IARB2HSSI] !== 32'h1) begin
            errors++;
            $display("FAIL stall7_release got stall %b delta %h expected 0 00000001",
                     stall_flag[IARB2HSSI], snap_delta[IARB2HSSI]);
        end
    endtask

    task automatic test_timeout();
        int sv0, k, t_err;
        logic [N-1:0][CW-1:0] ms;
        sv0 = sv_count;
        drop_idx = IWADJ2IARB_CH2;
        push_addrs(IWADJ2IARB_CH2 + 1);
        pulse_start();
        k = 0;
        while (err_timeout !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        t_err = cyc;
        checks++;
        if (err_timeout !== 1'b1 || err_idx !== 3'd5) begin
            errors++;
            $display("FAIL timeout_flag got %b idx %0d expected 1 idx 5", err_timeout, err_idx);
        end
        checks++;
        if (t_err - rd_cyc_last != TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d expected %0d", t_err - rd_cyc_last, TMO + 1);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) ms[i] = m_snap[i];
        checks++;
        if (busy !== 1'b0 || sv_count != sv0 || snap_cnt !== ms) begin
            errors++;
            $display("FAIL timeout_abort got busy %b snaps %0d cnt %h expected 0 0 %h",
                     busy, sv_count - sv0, snap_cnt, ms);
        end
        inject_rdv = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sv_count != sv0) begin
            errors++;
            $display("FAIL idle_rdv got busy %b snaps %0d expected 0 0", busy, sv_count - sv0);
        end
        pulse_err_clr();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clr got %b expected 0", err_timeout);
        end
        drop_idx = -1;
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_reads got %0d pending expected 0", exp_addr_q.size());
        end
    endtask

    // Long-latency scan spanning a period tick, with start pulses hammering it.
    task automatic test_overrun();
        int sv0, k;
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre got %b expected 0", err_overrun);
        end
        lat = 50;
        enable = 1'b1;
        repeat (800) @(negedge clk);
        sv0 = sv_count;
        push_addrs(N);
        push_expect();
        k = 0;
        while (snap_valid !== 1'b1 && k < 700) begin
            start = (k % 4 == 0);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        enable = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (sv_count - sv0 != 1) begin
            errors++;
            $display("FAIL overrun_snaps got %0d expected 1", sv_count - sv0);
        end
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got %b expected 1", err_overrun);
        end
        pulse_err_clr();
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr got %b expected 0", err_overrun);
        end
        lat = 2;
    endtask

    task automatic test_reset_mid_scan();
        int k, sv0;
        lat = 4;
        push_addrs(IWADJ2IARB_CH1 + 1);
        pulse_start();
        k = 0;
        while (!(avmm_read === 1'b1 && avmm_address === 8'd4) && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (avmm_read !== 1'b0 || busy !== 1'b0 || snap_valid !== 1'b0 || avmm_address !== '0) begin
            errors++;
            $display("FAIL midreset_bus got rd %b busy %b sv %b addr %0d expected 0 0 0 0",
                     avmm_read, busy, snap_valid, avmm_address);
        end
        checks++;
        if (snap_cnt !== '0 || snap_delta !== '0 || stall_flag !== '0 ||
            err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got cnt %h delta %h stall %b expected zeros",
                     snap_cnt, snap_delta, stall_flag);
        end
        model_reset();
        sv0 = sv_count;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sv_count != sv0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL late_rdv got busy %b snaps %0d rsp %0d expected 0 0 0",
                     busy, sv_count - sv0, rsp_q.size());
        end
        lat = 2;
        run_scan("post_reset_scan");
        checks++;
        if (exp_addr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d addrs %0d snaps expected 0 0",
                     exp_addr_q.size(), exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        start = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_periodic_scan();
        test_wrap();
        test_stall();
        test_timeout();
        test_overrun();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
